// File: rtl/calc_pkg.sv
// Shared definitions for the sequential BCD calculator.
//   OP_*    : opcode encodings on the op input
//   state_t : controller states
//   pow10   : 10^n as a 64-bit value, used for the overflow threshold
package calc_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        CONV = 2'd2,
        LOAD = 2'd3
    } state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_serial.sv
// Serial binary-to-packed-BCD converter (shift-add-3), one input bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   load     : capture bin and clear the accumulator; RW shifts follow
//   bin      : binary value, consumed MSB first
//   busy     : high while more than one shift is still outstanding, so the
//              controller can leave its conversion state on the final shift edge
//   bcd      : accumulator; digit 0 in bits [3:0]. Final value is bin mod 10^DIGITS
module bin2bcd_serial
    import calc_pkg::*;
#(
    parameter int RW     = 12,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [RW-1:0]         bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CW = $clog2(RW + 1);

    logic [RW-1:0]       sh;
    logic [4*DIGITS-1:0] acc;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;   // shifts remaining

    // Add-3 correction: any digit >= 5 would carry past 9 when doubled.
    always_comb begin
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= bin;
            acc <= '0;
            cnt <= CW'(RW);
        end else if (cnt != '0) begin
            // Carry out of the top digit falls off here, giving mod 10^DIGITS.
            acc <= {adj[4*DIGITS-2:0], sh[RW-1]};
            sh  <= {sh[RW-2:0], 1'b0};
            cnt <= cnt - CW'(1);
        end
    end

    assign busy = (cnt > CW'(1));
    assign bcd  = acc;

endmodule

// File: rtl/calc_bcd_seq.sv
// Clocked add/sub/mul calculator with packed-BCD result for 7-segment decoders.
//   clk, rst : clock, asynchronous active-high reset
//   start    : operation request, a/b/op captured with it
//   op       : 00 add, 01 sub (sign/magnitude), 10 mul, 11 pass A
//   a, b     : unsigned W-bit operands
//   busy     : operation in flight
//   done     : one-cycle pulse when bcd/neg/ovf have just been updated
//   bcd      : DIGITS packed BCD digits, ones digit in [3:0]
//   neg      : subtract result was negative
//   ovf      : magnitude did not fit in DIGITS decimal digits
//
// Handshake: start is accepted only on an edge where busy=0; busy rises after
// that edge and falls on the edge that loads the result, in the same cycle done
// is high. A start seen while busy=1 is dropped, not queued. A start presented
// during the done cycle is accepted, since the controller is already idle.
module calc_bcd_seq
    import calc_pkg::*;
#(
    parameter int W      = 6,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [W-1:0]          a,
    input  logic [W-1:0]          b,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  neg,
    output logic                  ovf
);

    localparam int          RW    = 2 * W;
    localparam logic [63:0] LIMIT = pow10(DIGITS);

    state_t              state, state_next;
    logic [W-1:0]        a_r, b_r;
    logic [1:0]          op_r;
    logic                neg_r, ovf_r;
    logic [RW-1:0]       mag;
    logic                conv_busy;
    logic [4*DIGITS-1:0] conv_bcd;

    // Result magnitude; RW = 2W holds every case without loss.
    always_comb begin
        mag = '0;
        case (op_r)
            OP_ADD:  mag = RW'(a_r) + RW'(b_r);
            OP_SUB:  mag = (a_r >= b_r) ? RW'(a_r - b_r) : RW'(b_r - a_r);
            OP_MUL:  mag = RW'(a_r) * RW'(b_r);
            default: mag = RW'(a_r);
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    state_next = CONV;
            CONV:    if (!conv_busy) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r   <= '0;
            b_r   <= '0;
            op_r  <= '0;
            neg_r <= 1'b0;
            ovf_r <= 1'b0;
            done  <= 1'b0;
            bcd   <= '0;
            neg   <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE && start) begin
                a_r  <= a;
                b_r  <= b;
                op_r <= op;
            end
            if (state == CALC) begin
                neg_r <= (op_r == OP_SUB) && (a_r < b_r);
                ovf_r <= (64'(mag) >= LIMIT);
            end
            if (state == LOAD) begin
                bcd  <= conv_bcd;
                neg  <= neg_r;
                ovf  <= ovf_r;
                done <= 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

    bin2bcd_serial #(
        .RW     (RW),
        .DIGITS (DIGITS)
    ) u_conv (
        .clk  (clk),
        .rst  (rst),
        .load (state == CALC),
        .bin  (mag),
        .busy (conv_busy),
        .bcd  (conv_bcd)
    );

endmodule

// File: tb/tb_calc_bcd_seq.sv
module tb_calc_bcd_seq;

  localparam int W = 6;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, MUL = 2'b10, PASS = 2'b11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] a = '0, b = '0;
  logic busy0, done0, neg0, ovf0;
  logic busy1, done1, neg1, ovf1;
  logic [15:0] bcd0;
  logic [7:0]  bcd1;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  calc_bcd_seq #(.W(W), .DIGITS(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .op(op), .a(a), .b(b),
    .busy(busy0), .done(done0), .bcd(bcd0), .neg(neg0), .ovf(ovf0)
  );

  calc_bcd_seq #(.W(W), .DIGITS(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .op(op), .a(a), .b(b),
    .busy(busy1), .done(done1), .bcd(bcd1), .neg(neg1), .ovf(ovf1)
  );

  function automatic logic get_busy(input bit sel);
    return sel ? busy1 : busy0;
  endfunction
  function automatic logic get_done(input bit sel);
    return sel ? done1 : done0;
  endfunction
  function automatic logic [15:0] get_bcd(input bit sel);
    return sel ? {8'h00, bcd1} : bcd0;
  endfunction
  function automatic logic get_neg(input bit sel);
    return sel ? neg1 : neg0;
  endfunction
  function automatic logic get_ovf(input bit sel);
    return sel ? ovf1 : ovf0;
  endfunction

  // Reference: plain integer arithmetic, then decimal digits by repeated /10.
  task automatic model(input logic [1:0] o, input int x, input int y, input int digits,
                       output logic [15:0] e_bcd, output logic e_neg, output logic e_ovf);
    int m, p;
    case (o)
      ADD:     m = x + y;
      SUB:     m = (x >= y) ? x - y : y - x;
      MUL:     m = x * y;
      default: m = x;
    endcase
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    e_ovf = (m >= p);
    e_neg = (o == SUB) && (x < y);
    m = m % p;
    e_bcd = '0;
    for (int i = 0; i < digits; i++) begin
      e_bcd[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
  endtask

  // Drive one start pulse; returns at the negedge after the accepting edge.
  task automatic launch(input bit sel, input logic [1:0] o, input int x, input int y);
    @(negedge clk);
    op = o; a = W'(x); b = W'(y);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
  endtask

  // Waits (bounded) for done; cyc counts negedges until done seen,
  // bcyc counts negedges with busy high, including the current one.
  task automatic wait_done(input bit sel, output bit got, output int cyc, output int bcyc);
    got = 1'b0;
    cyc = 0;
    bcyc = get_busy(sel) ? 1 : 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (get_done(sel)) got = 1'b1;
      else if (get_busy(sel)) bcyc++;
    end
  endtask

  task automatic test_reset;
    bit got; int cyc, bcyc, dones;
    repeat (3) @(negedge clk);
    tests_run++; if ({busy0, done0, bcd0, neg0, ovf0} !== 20'h0) begin tests_failed++; $display("FAIL reset_dut0: got %h expected 0", {busy0, done0, bcd0, neg0, ovf0}); end
    tests_run++; if ({busy1, done1, bcd1, neg1, ovf1} !== 12'h0) begin tests_failed++; $display("FAIL reset_dut1: got %h expected 0", {busy1, done1, bcd1, neg1, ovf1}); end
    rst = 1'b0;
    // Leave a nonzero result in place before the mid-conversion reset.
    launch(0, ADD, 30, 12);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || bcd0 !== 16'h0042) begin tests_failed++; $display("FAIL pre_reset_result: got %h (done=%0d) expected 0042", bcd0, got); end
    launch(0, SUB, 3, 60);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++; if ({busy0, done0, bcd0, neg0, ovf0} !== 20'h0) begin tests_failed++; $display("FAIL async_reset: got %h expected 0", {busy0, done0, bcd0, neg0, ovf0}); end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) dones++;
    end
    tests_run++; if (dones !== 0) begin tests_failed++; $display("FAIL reset_discards: got %0d done/busy cycles expected 0", dones); end
    launch(0, ADD, 1, 1);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || bcd0 !== 16'h0002) begin tests_failed++; $display("FAIL post_reset_add: got %h (done=%0d) expected 0002", bcd0, got); end
  endtask

  task automatic test_add;
    bit got; int cyc, bcyc;
    launch(0, ADD, 37, 25);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got) begin tests_failed++; $display("FAIL add_timeout: got no done expected done"); end
    tests_run++; if (cyc !== 14) begin tests_failed++; $display("FAIL add_latency: got %0d expected 14", cyc); end
    tests_run++; if (bcyc !== 14) begin tests_failed++; $display("FAIL add_busy_cycles: got %0d expected 14", bcyc); end
    tests_run++; if ({bcd0, neg0, ovf0} !== {16'h0062, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL add_result: got %h/%b/%b expected 0062/0/0", bcd0, neg0, ovf0); end
    tests_run++; if (busy0 !== 1'b0) begin tests_failed++; $display("FAIL add_busy_at_done: got %b expected 0", busy0); end
    @(negedge clk);
    tests_run++; if (done0 !== 1'b0) begin tests_failed++; $display("FAIL add_done_width: got %b expected 0", done0); end
    tests_run++; if (bcd0 !== 16'h0062) begin tests_failed++; $display("FAIL add_hold: got %h expected 0062", bcd0); end
  endtask

  task automatic test_sub;
    bit got; int cyc, bcyc;
    launch(0, SUB, 12, 45);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || {bcd0, neg0, ovf0} !== {16'h0033, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL sub_neg: got %h/%b/%b expected 0033/1/0", bcd0, neg0, ovf0); end
    launch(0, SUB, 20, 20);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || {bcd0, neg0, ovf0} !== {16'h0000, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL sub_equal: got %h/%b/%b expected 0000/0/0", bcd0, neg0, ovf0); end
  endtask

  task automatic test_mul_pass;
    bit got; int cyc, bcyc;
    launch(0, MUL, 63, 63);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || {bcd0, neg0, ovf0} !== {16'h3969, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL mul_max: got %h/%b/%b expected 3969/0/0", bcd0, neg0, ovf0); end
    launch(0, PASS, 9, 50);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || {bcd0, neg0, ovf0} !== {16'h0009, 1'b0, 1'b0}) begin tests_failed++; $display("FAIL pass_a: got %h/%b/%b expected 0009/0/0", bcd0, neg0, ovf0); end
  endtask

  task automatic test_digits2;
    bit got; int cyc, bcyc;
    launch(1, MUL, 20, 7);
    wait_done(1, got, cyc, bcyc);
    tests_run++; if (!got || {bcd1, neg1, ovf1} !== {8'h40, 1'b0, 1'b1}) begin tests_failed++; $display("FAIL d2_mul_ovf: got %h/%b/%b expected 40/0/1", bcd1, neg1, ovf1); end
    tests_run++; if (cyc !== 14) begin tests_failed++; $display("FAIL d2_latency: got %0d expected 14", cyc); end
  endtask

  task automatic test_busy_ignore;
    bit got; int cyc, bcyc, extra;
    launch(0, SUB, 10, 30);
    repeat (3) @(negedge clk);
    op = MUL; a = 6'd50; b = 6'd50; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || cyc !== 10) begin tests_failed++; $display("FAIL ignore_latency: got %0d (done=%0d) expected 10", cyc, got); end
    tests_run++; if ({bcd0, neg0, ovf0} !== {16'h0020, 1'b1, 1'b0}) begin tests_failed++; $display("FAIL ignore_result: got %h/%b/%b expected 0020/1/0", bcd0, neg0, ovf0); end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (done0 || busy0) extra++;
    end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL ignore_not_queued: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    bit got; int cyc, bcyc;
    launch(0, ADD, 5, 6);
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || bcd0 !== 16'h0011) begin tests_failed++; $display("FAIL b2b_first: got %h (done=%0d) expected 0011", bcd0, got); end
    op = MUL; a = 6'd7; b = 6'd8; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    tests_run++; if (busy0 !== 1'b1) begin tests_failed++; $display("FAIL b2b_accept: got busy %b expected 1", busy0); end
    wait_done(0, got, cyc, bcyc);
    tests_run++; if (!got || cyc !== 14) begin tests_failed++; $display("FAIL b2b_latency: got %0d (done=%0d) expected 14", cyc, got); end
    tests_run++; if (bcd0 !== 16'h0056) begin tests_failed++; $display("FAIL b2b_second: got %h expected 0056", bcd0); end
  endtask

  task automatic test_random;
    bit got, sel; int cyc, bcyc, x, y;
    logic [1:0] o;
    logic [15:0] e_bcd;
    logic e_neg, e_ovf;
    for (int n = 0; n < 40; n++) begin
      sel = 1'($urandom_range(1, 0));
      o = 2'($urandom_range(3, 0));
      x = $urandom_range(63, 0);
      y = $urandom_range(63, 0);
      model(o, x, y, sel ? 2 : 4, e_bcd, e_neg, e_ovf);
      launch(sel, o, x, y);
      wait_done(sel, got, cyc, bcyc);
      tests_run++;
      if (!got || cyc !== 14 || get_bcd(sel) !== e_bcd || get_neg(sel) !== e_neg || get_ovf(sel) !== e_ovf) begin
        tests_failed++;
        $display("FAIL random dut%0d op=%0d a=%0d b=%0d: got %h/%b/%b lat %0d expected %h/%b/%b lat 14",
                 sel, o, x, y, get_bcd(sel), get_neg(sel), get_ovf(sel), cyc, e_bcd, e_neg, e_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_mul_pass();
    test_digits2();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
